// File: rtl/temp_seg_display.sv
// Signed temperature to BCD converter with a 4-digit multiplexed 7-segment driver.
// Optional macro DISP_LZ_BLANK_EN blanks leading zeros in the integer view.
module temp_seg_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] raw,
    input  logic [7:0]  id,
    input  logic [1:0]  sel,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(REFRESH_DIV - 1);

    localparam logic [4:0] C_MINUS = 5'd16;
    localparam logic [4:0] C_BLANK = 5'd17;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } convState_t;

    convState_t  r_state;
    logic [15:0] r_snapshot;
    logic [8:0]  r_bin;
    logic [11:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_negTmp;
    logic [3:0]  r_fracTmp;

    logic        r_neg;
    logic [3:0]  r_hund;
    logic [3:0]  r_tens;
    logic [3:0]  r_units;
    logic [3:0]  r_frac;

    logic [CW-1:0] r_scanCnt;
    logic [1:0]    r_digit;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic [12:0] w_t;
    logic [12:0] w_mag;
    logic [11:0] w_bcdAdj;
    logic [7:0]  w_fracBcd;
    logic [4:0]  w_code [4];

    function automatic logic [3:0] dabbleAdj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Truncated hundredths of frac/16, as two BCD digits
    function automatic logic [7:0] fracLut(input logic [3:0] f);
        case (f)
            4'd0:    return 8'h00;
            4'd1:    return 8'h06;
            4'd2:    return 8'h12;
            4'd3:    return 8'h18;
            4'd4:    return 8'h25;
            4'd5:    return 8'h31;
            4'd6:    return 8'h37;
            4'd7:    return 8'h43;
            4'd8:    return 8'h50;
            4'd9:    return 8'h56;
            4'd10:   return 8'h62;
            4'd11:   return 8'h68;
            4'd12:   return 8'h75;
            4'd13:   return 8'h81;
            4'd14:   return 8'h87;
            default: return 8'h93;
        endcase
    endfunction

    function automatic logic [6:0] segOf(input logic [4:0] c);
        case (c)
            5'd0:    return 7'h40;
            5'd1:    return 7'h79;
            5'd2:    return 7'h24;
            5'd3:    return 7'h30;
            5'd4:    return 7'h19;
            5'd5:    return 7'h12;
            5'd6:    return 7'h02;
            5'd7:    return 7'h78;
            5'd8:    return 7'h00;
            5'd9:    return 7'h10;
            5'd10:   return 7'h08;
            5'd11:   return 7'h03;
            5'd12:   return 7'h46;
            5'd13:   return 7'h21;
            5'd14:   return 7'h06;
            5'd15:   return 7'h0E;
            5'd16:   return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    assign w_t   = r_snapshot[15:3];
    assign w_mag = w_t[12] ? (13'h0 - w_t) : w_t;

    assign w_bcdAdj = {dabbleAdj(r_bcd[11:8]), dabbleAdj(r_bcd[7:4]), dabbleAdj(r_bcd[3:0])};
    assign w_fracBcd = fracLut(r_frac);

    // busy also covers the IDLE cycle that sees a fresh reading, so back-to-back conversions never drop it
    assign busy = (r_state != S_IDLE) || (raw != r_snapshot);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_snapshot <= '0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_negTmp   <= 1'b0;
            r_fracTmp  <= '0;
            r_neg      <= 1'b0;
            r_hund     <= '0;
            r_tens     <= '0;
            r_units    <= '0;
            r_frac     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (raw != r_snapshot) begin
                        r_snapshot <= raw;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_negTmp  <= w_t[12];
                    r_bin     <= w_mag[12:4];
                    r_fracTmp <= w_mag[3:0];
                    r_bcd     <= '0;
                    r_cnt     <= '0;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_bcd <= {w_bcdAdj[10:0], r_bin[8]};
                    r_bin <= {r_bin[7:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd8) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_neg   <= r_negTmp;
                    r_hund  <= r_bcd[11:8];
                    r_tens  <= r_bcd[7:4];
                    r_units <= r_bcd[3:0];
                    r_frac  <= r_fracTmp;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_code[3] = C_BLANK;
        w_code[2] = C_BLANK;
        w_code[1] = C_BLANK;
        w_code[0] = C_BLANK;
        case (sel)
            2'b00: begin
                w_code[3] = r_neg ? C_MINUS : C_BLANK;
                w_code[2] = {1'b0, r_hund};
                w_code[1] = {1'b0, r_tens};
                w_code[0] = {1'b0, r_units};
`ifdef DISP_LZ_BLANK_EN
                if (r_hund == 4'd0) begin
                    w_code[2] = C_BLANK;
                    if (r_tens == 4'd0) begin
                        w_code[1] = C_BLANK;
                    end
                end
`endif
            end
            2'b01: begin
                w_code[2] = {1'b0, r_units};
                w_code[1] = {1'b0, w_fracBcd[7:4]};
                w_code[0] = {1'b0, w_fracBcd[3:0]};
            end
            2'b10: begin
                w_code[1] = {1'b0, id[7:4]};
                w_code[0] = {1'b0, id[3:0]};
            end
            default: begin
                w_code[3] = {1'b0, raw[15:12]};
                w_code[2] = {1'b0, raw[11:8]};
                w_code[1] = {1'b0, raw[7:4]};
                w_code[0] = {1'b0, raw[3:0]};
            end
        endcase
    end

    // Digit scan: the display registers follow the digit index one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scanCnt <= '0;
            r_digit   <= '0;
            r_an      <= 4'hF;
            r_seg     <= 7'h7F;
            r_dp      <= 1'b1;
        end else begin
            if (r_scanCnt == SCAN_LAST) begin
                r_scanCnt <= '0;
                r_digit   <= r_digit + 2'd1;
            end else begin
                r_scanCnt <= r_scanCnt + 1'b1;
            end
            r_an  <= ~(4'b0001 << r_digit);
            r_seg <= segOf(w_code[r_digit]);
            r_dp  <= ~((sel == 2'b01) && (r_digit == 2'd2));
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
